// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default sizes,
// reset PC, the NOP encoding and the fetched-entry layout.
package fetch_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int IMEM_WORDS_DEF = 32;
  localparam int DEPTH_DEF      = 2;
  localparam int RESET_PC_DEF   = 0;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // One prefetch entry: the word index it came from plus the instruction word.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle for the fetch unit: instruction-memory read port and the
// valid/ready handshake towards decode. master = fetch unit side.
interface instruction_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] imem_pc;
  logic [31:0]       imem_instr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_pc,
    input  imem_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular prefetch FIFO. The head is read straight out of the
// storage registers, so outputs carry no combinational path from inputs.
// flush is synchronous and wins over push/pop; rst is asynchronous.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage, pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign rdata = mem[rd_ptr];
  assign valid = (count_q != '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch-side initiator: owns the PC, reads the combinational instruction
// memory, queues {pc, instr} in a prefetch FIFO and hands entries to decode.
// A redirect flushes the queue and reloads the PC (taking priority over fetch).
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                IMEM_WORDS = IMEM_WORDS_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
  parameter int                DEPTH      = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  instruction_fetch_unit_if.master   bus
);

  // IMEM_WORDS is a power of two, so the last index doubles as the wrap mask.
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_WORDS - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic              fifo_valid;
  entry_t            push_entry;
  entry_t            head_entry;

  assign pc_inc     = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_W'(1);
  assign pop        = fifo_valid & bus.out_ready;
  assign push       = fetch_en & ~redirect_valid & (~fifo_full | pop);
  assign push_entry = '{pc: pc_q, instr: bus.imem_instr};

  // PC register: redirect target (wrapped to memory size) beats sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc & LAST_PC;
    end else if (push) begin
      pc_q <= pc_inc;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .valid (fifo_valid),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign bus.imem_pc   = pc_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_instr = head_entry.instr;
  assign bus.out_pc    = head_entry.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit with a
// 32-word combinational instruction memory model.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int IMEM_WORDS = 32;
  localparam int DEPTH      = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fetch_en = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [1:0]        fifo_count;
  logic [31:0]       imem [IMEM_WORDS];

  int tests_run    = 0;
  int tests_failed = 0;

  instruction_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_fetch_unit #(
    .ADDR_W     (ADDR_W),
    .IMEM_WORDS (IMEM_WORDS),
    .RESET_PC   (32'd0),
    .DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fifo_count     (fifo_count),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr = imem[bus.imem_pc[4:0]];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge act, sample at the next falling edge.
  task automatic applyStimulus(input logic fe, input logic rdy, input logic rv,
                               input logic [31:0] rpc);
    fetch_en       = fe;
    bus.out_ready  = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    checkOutput({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, " pc"}, bus.out_pc, pc);
    checkOutput({tag, " instr"}, bus.out_instr, instr);
  endtask

  task automatic checkEmpty(input string tag, input logic [31:0] pc);
    checkOutput({tag, " valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, " count"}, 32'(fifo_count), 32'd0);
    checkOutput({tag, " imem_pc"}, bus.imem_pc, pc);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) begin
      imem[i] = 32'hF000_0000 | 32'(i);
    end
    imem[0] = 32'h3903_0008;
    imem[1] = 32'h88C6_3000;
    imem[2] = 32'h8C22_000C;
    imem[3] = 32'h8867_2800;
    imem[4] = 32'h8845_2001;
    imem[5] = 32'h0800_0006;
    imem[6] = 32'h8883_2800;
    imem[7] = 32'h0800_0000;

    // Reset state, then streaming with decode always ready.
    rst           = 1'b1;
    fetch_en      = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkEmpty("reset", 32'd0);
    checkOutput("reset out_pc", bus.out_pc, 32'd0);
    checkOutput("reset out_instr", bus.out_instr, INSTR_NOP);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t1 first", 32'd0, 32'h3903_0008);
    checkOutput("t1 imem_pc", bus.imem_pc, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t1 second", 32'd1, 32'h88C6_3000);
    checkOutput("t1 count", 32'(fifo_count), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t1 third", 32'd2, 32'h8C22_000C);

    // Backpressure: FIFO fills to DEPTH and the PC freezes, then drains in order.
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("t2 count full", 32'(fifo_count), 32'd2);
    checkOutput("t2 imem_pc frozen", bus.imem_pc, 32'd2);
    checkHead("t2 head held", 32'd0, 32'h3903_0008);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t2 drain1", 32'd1, 32'h88C6_3000);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t2 drain2", 32'd2, 32'h8C22_000C);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t2 drain3", 32'd3, 32'h8867_2800);
    checkOutput("t2 count", 32'(fifo_count), 32'd2);
    checkOutput("t2 imem_pc", bus.imem_pc, 32'd5);

    // Redirect to 6 while pcs 3,4 are queued: both are discarded.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd6);
    checkEmpty("t3 flush", 32'd6);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t3 target", 32'd6, 32'h8883_2800);

    // Redirect coinciding with a pop and fetch_en: no push, PC takes the target.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd2);
    checkEmpty("t4 flush", 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t4 target", 32'd2, 32'h8C22_000C);
    checkOutput("t4 imem_pc", bus.imem_pc, 32'd3);

    // PC wraps from the last word to 0; oversized redirect target is reduced mod 32.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd30);
    checkEmpty("t5 redirect30", 32'd30);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t5 pc30", 32'd30, 32'hF000_001E);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t5 pc31", 32'd31, 32'hF000_001F);
    checkOutput("t5 wrap imem_pc", bus.imem_pc, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t5 pc0", 32'd0, 32'h3903_0008);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0025);
    checkEmpty("t5 redirect25", 32'd5);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t5 pc5", 32'd5, 32'h0800_0006);

    // fetch_en low: queue drains, PC holds.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkEmpty("fe0 drain", 32'd6);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkEmpty("fe0 hold", 32'd6);

    // Fill the FIFO, then hit reset mid-cycle: everything clears immediately.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("t6 count full", 32'(fifo_count), 32'd2);
    checkOutput("t6 imem_pc frozen", bus.imem_pc, 32'd8);
    checkHead("t6 head held", 32'd6, 32'h8883_2800);
    #2;
    rst = 1'b1;
    #1;
    checkEmpty("t6 async reset", 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t6 restart0", 32'd0, 32'h3903_0008);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("t6 restart1", 32'd1, 32'h88C6_3000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
